// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide run on magnitudes; signs are applied in FIX.
module mul_div_unit (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_m;
  logic [2*W-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic            r_busy;
  logic            r_done;

  state_t          w_state_nxt;
  logic            w_accept;
  logic [W-1:0]    w_mag_a;
  logic [W-1:0]    w_mag_b;
  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_mul_nxt;
  logic [W:0]      w_rem_sh;
  logic [W:0]      w_diff;
  logic [2*W-1:0]  w_div_nxt;
  logic            w_signed;
  logic            w_neg;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_quo;
  logic [W-1:0]    w_rem;
  logic [W-1:0]    w_fix_hi;
  logic [W-1:0]    w_fix_lo;

  // Next-state logic; a start is taken in IDLE or in the FIX cycle (back-to-back).
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CW'(W - 1)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand magnitudes at entry, one iteration step, and sign fix-up of the final value.
  always_comb begin
    w_mag_a   = (!op[0] && a[W-1]) ? (~a + W'(1)) : a;
    w_mag_b   = (!op[0] && b[W-1]) ? (~b + W'(1)) : b;

    w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_m} : (W+1)'(0));
    w_mul_nxt = {w_sum, r_acc[W-1:1]};

    w_rem_sh  = {r_acc[2*W-1:W], r_acc[W-1]};
    w_diff    = w_rem_sh - {1'b0, r_m};
    w_div_nxt = w_diff[W] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                          : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};

    w_signed  = ~r_op[0];
    w_neg     = w_signed & (r_a[W-1] ^ r_b[W-1]);
    w_prod    = w_neg ? (~r_acc + (2*W)'(1)) : r_acc;
    w_quo     = w_neg ? (~r_acc[W-1:0] + W'(1)) : r_acc[W-1:0];
    w_rem     = (w_signed && r_a[W-1]) ? (~r_acc[2*W-1:W] + W'(1)) : r_acc[2*W-1:W];

    w_fix_hi  = w_prod[2*W-1:W];
    w_fix_lo  = w_prod[W-1:0];
    if (r_op[1]) begin
      if (r_b == W'(0)) begin
        w_fix_hi = r_a;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_FIX);

      if (w_accept) begin
        r_op  <= op;
        r_a   <= a;
        r_b   <= b;
        r_m   <= op[1] ? w_mag_b : w_mag_a;
        r_acc <= {W'(0), (op[1] ? w_mag_a : w_mag_b)};
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= r_op[1] ? w_div_nxt : w_mul_nxt;
        r_cnt <= r_cnt + CW'(1);
      end

      // HI/LO change only at FIX or on moves while idle; a start suppresses moves.
      if (r_state == S_FIX) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (r_state == S_IDLE && !start) begin
        if (mthi) r_hi <= a;
        if (mtlo) r_lo <= a;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model plus directed and random stimulus.
module tb_mul_div_unit;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  mul_div_unit dut (
    .clk_in (clk_in),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  // Returns {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      2'd0: res = 64'(sx * sy);
      2'd1: res = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Cycle-level expectation: an accepted op completes 33 edges later.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done;
  int          m_rem = 0;
  bit          m_valid = 1'b0;
  bit          m_idle, m_fin;
  logic [63:0] m_r;

  always @(posedge clk_in) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_valid = 1'b1;
    end else begin
      m_idle = (m_rem == 0);
      m_fin  = (m_rem == 1);
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end
      if (start && (m_idle || m_fin)) begin
        m_r = ref_calc(op, a, b);
        p_hi = m_r[63:32];
        p_lo = m_r[31:0];
        m_rem = 33;
      end else if (m_idle) begin
        if (mthi) m_hi = a;
        if (mtlo) m_lo = a;
      end
      m_busy = (m_rem > 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_in);
      if (m_valid) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
      end
    end
  endtask

  task automatic clk1();
    @(negedge clk_in);
  endtask

  task automatic idle_in();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: v = 32'h7FFFFFFF;
      5: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op, scramble operands while it runs, and wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    op = o; a = x; b = y; start = 1'b1;
    clk1();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      op = 2'($urandom); a = $urandom; b = $urandom;
      clk1();
      lat++;
    end
    if (!done) chk("op_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int k;
    bit saw_done;
    logic [63:0] r;

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = '0; a = '0; b = '0;
    fork
      monitor();
    join_none

    r = ref_calc(2'd0, 32'hFFFFFFFD, 32'd5);
    chk("ref_mult_hi", r[63:32], 32'hFFFFFFFF);
    chk("ref_mult_lo", r[31:0], 32'hFFFFFFF1);
    r = ref_calc(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("ref_multu_hi", r[63:32], 32'hFFFFFFFE);
    chk("ref_multu_lo", r[31:0], 32'h00000001);
    r = ref_calc(2'd2, 32'hFFFFFFF9, 32'd2);
    chk("ref_div_hi", r[63:32], 32'hFFFFFFFF);
    chk("ref_div_lo", r[31:0], 32'hFFFFFFFD);
    r = ref_calc(2'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("ref_divwrap_hi", r[63:32], 32'h0);
    chk("ref_divwrap_lo", r[31:0], 32'h80000000);

    clk1(); clk1();
    idle_in();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);

    run_op(2'd0, 32'hFFFFFFFD, 32'd5, lat);
    chk("mult_latency", 32'(lat), 32'd34);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    run_op(2'd2, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);

    run_op(2'd3, 32'd7, 32'd0, lat);
    chk("divz_latency", 32'(lat), 32'd34);
    chk("divz_hi", hi, 32'd7);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_busy", 32'(busy), 32'd0);

    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("divwrap_hi", hi, 32'h0);
    chk("divwrap_lo", lo, 32'h80000000);

    a = 32'h12345678; mtlo = 1'b1;
    clk1();
    idle_in();
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi", hi, 32'h0);

    op = 2'd1; a = 32'hAAAA5555; b = 32'd2; start = 1'b1; mthi = 1'b1;
    clk1();
    idle_in();
    chk("start_mthi_hi", hi, 32'h0);
    k = 0;
    while (!done && k < 60) begin clk1(); k++; end
    chk("start_mthi_res_hi", hi, 32'h1);
    chk("start_mthi_res_lo", lo, 32'h5554AAAA);

    // MULT 6*7 interrupted: ignored start and mthi while busy, then reset.
    op = 2'd0; a = 32'd6; b = 32'd7; start = 1'b1;
    clk1();
    idle_in();
    saw_done = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == 5)  begin start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd3; end
      if (cyc == 10) begin mthi = 1'b1; a = 32'hDEADBEEF; end
      if (cyc == 12) reset = 1'b1;
      clk1();
      if (done) saw_done = 1'b1;
      idle_in();
    end
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      clk1();
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    run_op(2'd1, 32'd3, 32'd4, lat);
    chk("after_abort_lo", lo, 32'd12);
    chk("after_abort_hi", hi, 32'd0);

    // Random traffic: starts while busy, back-to-back starts, moves, occasional reset.
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      mthi  = ($urandom_range(0, 11) == 0);
      mtlo  = ($urandom_range(0, 11) == 0);
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      clk1();
    end
    idle_in();
    for (int i = 0; i < 40; i++) clk1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001: clk_in  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset, sampled on the clk_in rising edge.
REQ-003: start  input  1  one-cycle request to begin the operation selected by op.
REQ-004: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005: a  input  32  operand rs (multiplicand / dividend), taken from register file rdata1.
REQ-006: b  input  32  operand rt (multiplier / divisor), taken from register file rdata2.
REQ-007: mthi  input  1  write a into HI.
REQ-008: mtlo  input  1  write a into LO.
REQ-009: hi  output  32  HI register; read path for MFHI.
REQ-010: lo  output  32  LO register; read path for MFLO.
REQ-011: busy  output  1  operation in progress; the control unit stalls the PC clock while busy=1.
REQ-012: done  output  1  one-cycle pulse in the cycle after HI/LO receive a result.

Function
REQ-013: States: IDLE, CALC, FIX.
REQ-014: IDLE + start=1 at edge E0: latch op, a and b, clear the 6-bit iteration counter, go to CALC; busy=1 from E0 onward.
REQ-015: CALC runs exactly 32 iterations, one per edge (E1..E32); after E32 go to FIX.
REQ-016: FIX at E33: write the final HI and LO, go to IDLE, busy=0 and done=1 for the one cycle after E33.
REQ-017: Latency: start sampled at E0 -> result visible on hi/lo and done=1 after E33 (34 cycles); back-to-back start is accepted at E33.
REQ-018: Signed ops (MULT, DIV) iterate on operand magnitudes; signs are applied only in FIX.
REQ-019: Multiply: shift-add over a 64-bit product; HI = product[63:32], LO = product[31:0].
REQ-020: MULT result is negated in FIX when a[31] XOR b[31].
REQ-021: Divide: restoring algorithm, 32 quotient bits MSB-first; LO = quotient, HI = remainder.
REQ-022: DIV quotient sign = a[31] XOR b[31]; DIV remainder sign = a[31]; the identity a = q*b + r holds.
REQ-023: Divide by zero (b=0, DIV or DIVU): LO = 32'hFFFFFFFF, HI = a unchanged; latency unchanged; no error output.
REQ-024: DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0; this is the natural wrap result.
REQ-025: start while busy=1 is ignored, with no queueing.
REQ-026: mthi/mtlo while busy=1 are ignored.
REQ-027: In IDLE, mthi/mtlo write at the edge; both set = both HI and LO receive a.
REQ-028: start together with mthi/mtlo in IDLE: start wins and the moves are dropped.
REQ-029: hi/lo hold their value throughout CALC and change only at FIX, on mthi/mtlo, or on reset.
REQ-030: op/a/b changes after E0 do not affect the running operation.

Reset
REQ-031: reset=1 at an edge: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operand registers = 0.
REQ-032: Reset takes priority over start, mthi and mtlo in the same cycle.
REQ-033: Reset mid-CALC or at FIX aborts the operation with no partial HI/LO write.
REQ-034: A start in the first cycle after reset deasserts is accepted normally.

Verification
REQ-035: MULT a=32'hFFFFFFFD (-3), b=5 -> done after 34 cycles, hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-036: MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-037: DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-038: DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7, busy low after 34 cycles.
REQ-039: MULT 6*7, then: start (op=DIV) in cycle 5 and mthi in cycle 10 are ignored; reset in cycle 12 -> hi=lo=0, busy=0, done never pulses; next MULTU 3*4 -> lo=12, hi=0.
REQ-040: Idle: mtlo with a=32'h12345678 -> lo=32'h12345678, hi unchanged; start+mthi same cycle -> hi unchanged until FIX.
